btn_event_scheduler: RTL and testbench

- Collects edge pulses from NUM_BTN button_detector instances and latches each one as a pending event.
- Serializes pending events onto one valid/ready event port, sharing it between channels by round-robin.
- Sits between the per-button detectors and the consumer: a UART reporter, mode FSM or LED/FND controller.
- Lossless up to one outstanding event per type per channel; anything beyond that is flagged as overflow.

---
 rtl/btn_event_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_btn_event_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_scheduler.sv
// ---------------------------------------------------------------------------
// btn_event_scheduler
//
// Purpose:
//   Collects rising/falling edge pulses from NUM_BTN button detectors and
//   latches each one as a pending event. Pending events are sent one at a
//   time on a single valid/ready event port. Channels share the port by
//   round-robin arbitration. Within a channel the type order is press, then
//   long press, then release. Each channel/type can hold one outstanding
//   event. A further event of that type before it drains is lost and sets
//   the sticky overflow flag.
//
// Handshake (valid/ready):
//   o_evt_valid is asserted while an event is presented. o_evt_ch and
//   o_evt_type stay stable until a cycle with i_evt_ready=1. The transfer
//   occurs on the rising clk edge where o_evt_valid && i_evt_ready. Valid
//   never drops without a transfer, except through reset.
//
// Optional feature (macro BTN_LONG_PRESS_EN):
//   Defined   : per-channel hold counter. A long-press event (type 2'b10) is
//               raised once per press after LONG_MS i_tick strobes.
//   Undefined : no long-press logic; i_tick and LONG_MS are ignored.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   i_rise       per-channel press pulse
//   i_fall       per-channel release pulse
//   i_tick       1 kHz strobe (long-press timing only)
//   o_evt_valid  event presented
//   i_evt_ready  consumer accepts event
//   o_evt_ch     channel of the presented event
//   o_evt_type   00 press, 01 release, 10 long press
//   o_pending    per channel, OR of that channel's pending bits (registered)
//   o_overflow   sticky event-lost flag
//   i_clr_ovf    clears o_overflow (a simultaneous new loss wins)
// ---------------------------------------------------------------------------
module btn_event_scheduler #(
  parameter int  NUM_BTN = 4,
  parameter int  LONG_MS = 1000,
  localparam int CH_W    = $clog2(NUM_BTN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] i_rise,
  input  logic [NUM_BTN-1:0] i_fall,
  input  logic               i_tick,
  output logic               o_evt_valid,
  input  logic               i_evt_ready,
  output logic [CH_W-1:0]    o_evt_ch,
  output logic [1:0]         o_evt_type,
  output logic [NUM_BTN-1:0] o_pending,
  output logic               o_overflow,
  input  logic               i_clr_ovf
);

  localparam logic [1:0] TYPE_PRESS   = 2'b00;
  localparam logic [1:0] TYPE_RELEASE = 2'b01;
  localparam logic [1:0] TYPE_LONG    = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NUM_BTN-1:0] r_press_p;
  logic [NUM_BTN-1:0] r_rel_p;
  logic [CH_W-1:0]    r_ptr;
  logic [CH_W-1:0]    r_evt_ch;
  logic [1:0]         r_evt_type;
  logic [NUM_BTN-1:0] r_pending;
  logic               r_overflow;

  // Long-press pending bits and their set strobes (constant zero when the
  // feature is compiled out).
  logic [NUM_BTN-1:0] w_long_pend;
  logic [NUM_BTN-1:0] w_long_set;

  logic [NUM_BTN-1:0] w_any_ch;
  logic               w_found;
  logic [CH_W-1:0]    w_gnt_ch;
  logic [1:0]         w_gnt_type;
  logic               w_load;
  logic [NUM_BTN-1:0] w_gnt_onehot;
  logic [NUM_BTN-1:0] w_clr_press;
  logic [NUM_BTN-1:0] w_clr_rel;
  logic [NUM_BTN-1:0] w_clr_long;
  logic [NUM_BTN-1:0] w_press_nxt;
  logic [NUM_BTN-1:0] w_rel_nxt;
  logic [NUM_BTN-1:0] w_long_nxt;
  logic               w_loss;

  assign w_any_ch = r_press_p | r_rel_p | w_long_pend;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    int idx;
    w_found    = 1'b0;
    w_gnt_ch   = '0;
    w_gnt_type = TYPE_PRESS;
    idx        = 0;
    for (int i = 1; i <= NUM_BTN; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= NUM_BTN) idx = idx - NUM_BTN;
      if (!w_found && w_any_ch[idx]) begin
        w_found  = 1'b1;
        w_gnt_ch = CH_W'(idx);
      end
    end
    // Press before long before release keeps press/release ordering intact.
    if (r_press_p[w_gnt_ch])        w_gnt_type = TYPE_PRESS;
    else if (w_long_pend[w_gnt_ch]) w_gnt_type = TYPE_LONG;
    else                            w_gnt_type = TYPE_RELEASE;
  end

  assign w_load       = ((r_state == ST_IDLE) || i_evt_ready) && w_found;
  assign w_gnt_onehot = NUM_BTN'(1) << w_gnt_ch;
  assign w_clr_press  = (w_load && (w_gnt_type == TYPE_PRESS))   ? w_gnt_onehot : '0;
  assign w_clr_rel    = (w_load && (w_gnt_type == TYPE_RELEASE)) ? w_gnt_onehot : '0;
  assign w_clr_long   = (w_load && (w_gnt_type == TYPE_LONG))    ? w_gnt_onehot : '0;

  // Clear is applied before set, so a new event arriving on the cycle its
  // bit is loaded survives without counting as a loss.
  assign w_press_nxt = (r_press_p & ~w_clr_press) | i_rise;
  assign w_rel_nxt   = (r_rel_p   & ~w_clr_rel)   | i_fall;
  assign w_long_nxt  = (w_long_pend & ~w_clr_long) | w_long_set;

  assign w_loss = |((i_rise     & r_press_p   & ~w_clr_press) |
                    (i_fall     & r_rel_p     & ~w_clr_rel)   |
                    (w_long_set & w_long_pend & ~w_clr_long));

`ifdef BTN_LONG_PRESS_EN
  localparam int CNT_W = $clog2(LONG_MS + 1);

  logic [NUM_BTN-1:0] r_held;
  logic [NUM_BTN-1:0] r_long_p;
  logic [CNT_W-1:0]   r_cnt [NUM_BTN];

  assign w_long_pend = r_long_p;

  // The tick that moves the counter from LONG_MS-1 to LONG_MS raises the
  // event; the counter then saturates, so it fires once per press.
  always_comb begin
    w_long_set = '0;
    for (int c = 0; c < NUM_BTN; c++) begin
      w_long_set[c] = r_held[c] && i_tick && !i_rise[c] && !i_fall[c] &&
                      (r_cnt[c] == CNT_W'(LONG_MS - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_held   <= '0;
      r_long_p <= '0;
      for (int c = 0; c < NUM_BTN; c++) r_cnt[c] <= '0;
    end else begin
      r_long_p <= w_long_nxt;
      for (int c = 0; c < NUM_BTN; c++) begin
        if (i_rise[c]) begin
          r_held[c] <= 1'b1;
          r_cnt[c]  <= '0;
        end else if (i_fall[c]) begin
          r_held[c] <= 1'b0;
          r_cnt[c]  <= '0;
        end else if (r_held[c] && i_tick && (r_cnt[c] != CNT_W'(LONG_MS))) begin
          r_cnt[c] <= r_cnt[c] + 1'b1;
        end
      end
    end
  end
`else
  assign w_long_pend = '0;
  assign w_long_set  = '0;

  logic w_unused_long;
  assign w_unused_long = i_tick ^ (LONG_MS == 0) ^ (|w_clr_long) ^ (|w_long_nxt);
`endif

  // Output-stage FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Output-stage FSM: next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    if (w_load)                                    w_state_nxt = ST_SHOW;
    else if ((r_state == ST_SHOW) && i_evt_ready)  w_state_nxt = ST_IDLE;
  end

  // Output-stage FSM: outputs.
  always_comb begin
    o_evt_valid = (r_state == ST_SHOW);
  end

  // Datapath: pending bits, presented event, pointer, flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_press_p  <= '0;
      r_rel_p    <= '0;
      r_ptr      <= '0;
      r_evt_ch   <= '0;
      r_evt_type <= '0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_press_p  <= w_press_nxt;
      r_rel_p    <= w_rel_nxt;
      r_pending  <= w_press_nxt | w_rel_nxt | w_long_nxt;
      r_overflow <= (r_overflow & ~i_clr_ovf) | w_loss;
      if (w_load) begin
        r_evt_ch   <= w_gnt_ch;
        r_evt_type <= w_gnt_type;
        r_ptr      <= w_gnt_ch;
      end
    end
  end

  assign o_evt_ch   = r_evt_ch;
  assign o_evt_type = r_evt_type;
  assign o_pending  = r_pending;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_btn_event_scheduler.sv
// ---------------------------------------------------------------------------
// tb_btn_event_scheduler
//
// Directed bench for btn_event_scheduler. The event-level model tracks the
// pending events per channel and the presented event. A negedge process
// compares the DUT against that model every cycle. The same process also
// pops the hand-written expected transfer list (exp_q).
// ---------------------------------------------------------------------------
module tb_btn_event_scheduler;

  localparam int NUM_BTN = 4;
  localparam int LONG_MS = 5;
  localparam int CH_W    = $clog2(NUM_BTN);
  localparam int W       = CH_W + 2;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [NUM_BTN-1:0] i_rise = '0;
  logic [NUM_BTN-1:0] i_fall = '0;
  logic               i_tick = 1'b0;
  logic               o_evt_valid;
  logic               i_evt_ready = 1'b0;
  logic [CH_W-1:0]    o_evt_ch;
  logic [1:0]         o_evt_type;
  logic [NUM_BTN-1:0] o_pending;
  logic               o_overflow;
  logic               i_clr_ovf = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  btn_event_scheduler #(.NUM_BTN(NUM_BTN), .LONG_MS(LONG_MS)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_rise      (i_rise),
    .i_fall      (i_fall),
    .i_tick      (i_tick),
    .o_evt_valid (o_evt_valid),
    .i_evt_ready (i_evt_ready),
    .o_evt_ch    (o_evt_ch),
    .o_evt_type  (o_evt_type),
    .o_pending   (o_pending),
    .o_overflow  (o_overflow),
    .i_clr_ovf   (i_clr_ovf)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- event-level model ----------------
  bit m_press [NUM_BTN];
  bit m_rel   [NUM_BTN];
  bit m_long  [NUM_BTN];
  bit m_held  [NUM_BTN];
  int m_cnt   [NUM_BTN];
  bit m_valid;
  bit m_ovf;
  int m_ch;
  int m_type;
  int m_ptr;
  int m_c;
  bit m_found;
  bit m_loss;

  always @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_BTN; c++) begin
        m_press[c] = 0; m_rel[c] = 0; m_long[c] = 0; m_held[c] = 0; m_cnt[c] = 0;
      end
      m_valid = 0; m_ovf = 0; m_ch = 0; m_type = 0; m_ptr = 0;
    end else begin
      // Presented event: take the next one if the port is free or accepted.
      if (!m_valid || i_evt_ready) begin
        m_found = 0;
        m_c     = 0;
        for (int i = 1; i <= NUM_BTN; i++) begin
          m_c = (m_ptr + i) % NUM_BTN;
          if (m_press[m_c] || m_long[m_c] || m_rel[m_c]) begin
            m_found = 1;
            break;
          end
        end
        if (m_found) begin
          m_valid = 1;
          m_ch    = m_c;
          m_ptr   = m_c;
          if (m_press[m_c])     begin m_type = 0; m_press[m_c] = 0; end
          else if (m_long[m_c]) begin m_type = 2; m_long[m_c]  = 0; end
          else                  begin m_type = 1; m_rel[m_c]   = 0; end
        end else begin
          m_valid = 0;
        end
      end
      // New events arriving this cycle.
      m_loss = 0;
      for (int c = 0; c < NUM_BTN; c++) begin
        if (i_rise[c]) begin
          if (m_press[c]) m_loss = 1;
          m_press[c] = 1;
        end
        if (i_fall[c]) begin
          if (m_rel[c]) m_loss = 1;
          m_rel[c] = 1;
        end
`ifdef BTN_LONG_PRESS_EN
        if (i_rise[c]) begin
          m_held[c] = 1; m_cnt[c] = 0;
        end else if (i_fall[c]) begin
          m_held[c] = 0; m_cnt[c] = 0;
        end else if (m_held[c] && i_tick && m_cnt[c] < LONG_MS) begin
          m_cnt[c]++;
          if (m_cnt[c] == LONG_MS) begin
            if (m_long[c]) m_loss = 1;
            m_long[c] = 1;
          end
        end
`endif
      end
      m_ovf = (m_ovf && !i_clr_ovf) || m_loss;
    end
  end

  function automatic logic [NUM_BTN-1:0] model_pending();
    logic [NUM_BTN-1:0] p;
    p = '0;
    for (int c = 0; c < NUM_BTN; c++) p[c] = m_press[c] | m_rel[c] | m_long[c];
    return p;
  endfunction

  // ---------------- compare process + scoreboard ----------------
  logic [W-1:0] sb_got;
  logic [W-1:0] sb_exp;

  always @(negedge clk) begin
    chk("valid", 32'(o_evt_valid), 32'(m_valid));
    if (m_valid) begin
      chk("evt_ch", 32'(o_evt_ch), 32'(m_ch));
      chk("evt_type", 32'(o_evt_type), 32'(m_type));
    end
    chk("pending", 32'(o_pending), 32'(model_pending()));
    chk("overflow", 32'(o_overflow), 32'(m_ovf));
    if (!reset && o_evt_valid && i_evt_ready) begin
      sb_got = {o_evt_ch, o_evt_type};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_unexpected: got ch %0d type %0d expected no transfer at %0t",
                 o_evt_ch, o_evt_type, $time);
      end else begin
        sb_exp = exp_q.pop_front();
        chk("xfer", 32'(sb_got), 32'(sb_exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; i_rise = '0; i_fall = '0; i_tick = 1'b0; i_clr_ovf = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic pulse_rise(input logic [NUM_BTN-1:0] m);
    i_rise = m; step(1); i_rise = '0;
  endtask

  task automatic pulse_fall(input logic [NUM_BTN-1:0] m);
    i_fall = m; step(1); i_fall = '0;
  endtask

  task automatic push_exp(input int ch, input int typ);
    exp_q.push_back({CH_W'(ch), 2'(typ)});
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      i_tick = 1'b1; step(1); i_tick = 1'b0; step(1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    chk("rst_valid", 32'(o_evt_valid), 32'd0);
    chk("rst_pending", 32'(o_pending), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);

    // 1: single press, 1-cycle latency, valid for exactly one cycle.
    i_evt_ready = 1'b1;
    step(8);
    push_exp(2, 0);
    pulse_rise(4'b0100);
    chk("t1_valid_k", 32'(o_evt_valid), 32'd0);
    chk("t1_pending_k", 32'(o_pending), 32'h4);
    step(1);
    chk("t1_valid_k1", 32'(o_evt_valid), 32'd1);
    chk("t1_ch", 32'(o_evt_ch), 32'd2);
    chk("t1_type", 32'(o_evt_type), 32'd0);
    step(1);
    chk("t1_valid_k2", 32'(o_evt_valid), 32'd0);
    chk("t1_ovf", 32'(o_overflow), 32'd0);
    step(2);
    chk("t1_drain", 32'(exp_q.size()), 32'd0);

    // 2: simultaneous presses, round-robin from ptr=0 -> 1, 3, 0.
    do_reset();
    i_evt_ready = 1'b1;
    push_exp(1, 0); push_exp(3, 0); push_exp(0, 0);
    pulse_rise(4'b1011);
    step(1);
    chk("t2_first_ch", 32'(o_evt_ch), 32'd1);
    step(1);
    chk("t2_second_ch", 32'(o_evt_ch), 32'd3);
    step(1);
    chk("t2_third_ch", 32'(o_evt_ch), 32'd0);
    step(3);
    chk("t2_drain", 32'(exp_q.size()), 32'd0);

    // 3: stalled consumer, press held stable, release follows.
    do_reset();
    i_evt_ready = 1'b0;
    push_exp(1, 0); push_exp(1, 1);
    pulse_rise(4'b0010);
    pulse_fall(4'b0010);
    step(20);
    chk("t3_hold_valid", 32'(o_evt_valid), 32'd1);
    chk("t3_hold_ch", 32'(o_evt_ch), 32'd1);
    chk("t3_hold_type", 32'(o_evt_type), 32'd0);
    i_evt_ready = 1'b1;
    step(1);
    chk("t3_rel_type", 32'(o_evt_type), 32'd1);
    step(3);
    chk("t3_drain", 32'(exp_q.size()), 32'd0);

    // 4: overflow while port busy, set-wins on clear, then clear.
    do_reset();
    i_evt_ready = 1'b0;
    push_exp(1, 0); push_exp(0, 0);
    pulse_rise(4'b0010);
    step(1);
    pulse_rise(4'b0001);
    step(4);
    chk("t4_no_ovf_yet", 32'(o_overflow), 32'd0);
    pulse_rise(4'b0001);
    chk("t4_ovf_set", 32'(o_overflow), 32'd1);
    i_rise = 4'b0001; i_clr_ovf = 1'b1;
    step(1);
    i_rise = '0; i_clr_ovf = 1'b0;
    chk("t4_set_wins", 32'(o_overflow), 32'd1);
    i_clr_ovf = 1'b1;
    step(1);
    i_clr_ovf = 1'b0;
    chk("t4_ovf_clr", 32'(o_overflow), 32'd0);
    i_evt_ready = 1'b1;
    step(4);
    chk("t4_drain", 32'(exp_q.size()), 32'd0);

    // 4b: new press on the same cycle its bit is loaded is kept.
    do_reset();
    i_evt_ready = 1'b1;
    push_exp(0, 0); push_exp(0, 0);
    pulse_rise(4'b0001);
    pulse_rise(4'b0001);
    step(4);
    chk("t4b_ovf", 32'(o_overflow), 32'd0);
    chk("t4b_drain", 32'(exp_q.size()), 32'd0);

`ifdef BTN_LONG_PRESS_EN
    // 5a: hold across LONG_MS ticks -> press, long, release.
    do_reset();
    i_evt_ready = 1'b1;
    push_exp(3, 0); push_exp(3, 2); push_exp(3, 1);
    pulse_rise(4'b1000);
    ticks(7);
    pulse_fall(4'b1000);
    step(4);
    chk("t5a_drain", 32'(exp_q.size()), 32'd0);

    // 5b: short hold -> press, release only.
    do_reset();
    i_evt_ready = 1'b1;
    push_exp(3, 0); push_exp(3, 1);
    pulse_rise(4'b1000);
    ticks(3);
    pulse_fall(4'b1000);
    step(4);
    chk("t5b_drain", 32'(exp_q.size()), 32'd0);
`endif

    // 6: reset during SHOW with three bits still pending.
    do_reset();
    i_evt_ready = 1'b0;
    pulse_rise(4'b1111);
    step(1);
    chk("t6_show_ch", 32'(o_evt_ch), 32'd1);
    chk("t6_pending", 32'(o_pending), 32'hD);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t6_valid0", 32'(o_evt_valid), 32'd0);
    chk("t6_ch0", 32'(o_evt_ch), 32'd0);
    chk("t6_type0", 32'(o_evt_type), 32'd0);
    chk("t6_pending0", 32'(o_pending), 32'd0);
    chk("t6_ovf0", 32'(o_overflow), 32'd0);
    i_evt_ready = 1'b1;
    step(10);
    chk("t6_quiet", 32'(o_evt_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
